ddr2_ex_lfsr_sequencer: RTL and testbench
=========================================

Name: ddr2_ex_lfsr_sequencer

Overview:
- Sequences a bank of LANES 8-bit LFSR pattern generators in the DDR2 example driver.
- Write phase: seeds the LFSRs and steps them once per accepted write beat.
- Read phase: re-seeds the LFSRs to the same values and steps them once per returned read beat, comparing read data against the regenerated pattern per byte lane.
- Reports done plus sticky per-lane pass/fail; this is the single owner of the LFSR enable, pause, load and ldata controls.

Parameters:
- LANES, 4, number of 8-bit LFSR lanes (data width 8*LANES).
- BEATS_W, 8, width of the beat counter and of num_beats.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a test; ignored unless in IDLE.
- abort  in  1  synchronous return to IDLE from any state.
- num_beats  in  BEATS_W  beats per phase; sampled on accepted start.
- seed_in  in  8  base seed; lane i seed = seed_in + i, mod 256; sampled on accepted start.
- wr_ready  in  1  write beat accepted this cycle.
- rd_valid  in  1  read beat present on rd_data this cycle.
- rd_data  in  8*LANES  read data; lane i occupies bits [8i+7:8i].
- lfsr_data  in  8*LANES  concatenated LFSR data outputs.
- lfsr_enable  out  1  LFSR enable, shared by all lanes.
- lfsr_pause  out  1  LFSR pause, shared by all lanes.
- lfsr_load  out  1  LFSR load, shared by all lanes.
- lfsr_ldata  out  8*LANES  per-lane load seeds.
- wr_valid  out  1  write data (lfsr_data) is valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at test completion.
- fail  out  1  OR of fail_lane.
- fail_lane  out  LANES  sticky per-lane mismatch flags.

Behaviour:
- States: IDLE, LOAD_WR, WRITE, LOAD_RD, READ, DONE. Encoding is free. All outputs are registered or decoded from state only; no combinational path from inputs to outputs except lfsr_pause.
- Reset values: state=IDLE; lfsr_enable=0, lfsr_load=0, lfsr_pause=1, wr_valid=0, busy=0, done=0, fail_lane=0, beat counter=0, latched seed=0, latched num_beats=0.
- IDLE:
  - lfsr_enable=0, so the LFSRs hold their built-in seed.
  - On start: latch num_beats and seed_in, clear fail_lane and the counter.
  - If num_beats==0, go to DONE (pass). Otherwise go to LOAD_WR.
- LOAD_WR: one cycle; lfsr_enable=1, lfsr_load=1, lfsr_ldata=lane seeds; then WRITE.
- WRITE:
  - lfsr_enable=1, wr_valid=1, lfsr_pause = !wr_ready.
  - The counter increments on each wr_ready.
  - When wr_ready is high and counter==num_beats-1: clear the counter and go to LOAD_RD.
- LOAD_RD: one cycle, identical to LOAD_WR; then READ.
- READ:
  - lfsr_enable=1, lfsr_pause = !rd_valid.
  - On rd_valid: for each lane, fail_lane[i] |= (rd_data lane != lfsr_data lane), and the counter increments.
  - On the last beat (counter==num_beats-1): go to DONE.
  - rd_valid in any other state is ignored.
- DONE: done=1 for exactly one cycle, lfsr_enable=0; then IDLE. fail_lane holds until the next accepted start.
- Latency:
  - First write beat is presented 2 cycles after start.
  - The LFSR advances the cycle after each accepted beat.
  - The last read compare is visible on fail_lane the cycle after that beat.
- Boundaries:
  - Max test length is 2^BEATS_W-1 beats; counter compare is exact with no wrap.
  - start while busy is ignored.
  - abort has priority over every transition: go to IDLE, no done pulse, fail_lane retained.
  - abort and start in the same cycle in IDLE: abort wins and start is dropped.
  - reset_n low mid-test: immediate return to reset values.
  - Seed addition wraps: seed_in=0xFF, lane 1 seed = 0x00.

Test Plan:
- LANES=1, seed_in=0x20, num_beats=4, wr_ready always 1 -> write data 0x20,0x40,0x80,0x1D on 4 consecutive cycles starting 2 cycles after start; read data returned identically -> done pulse, fail=0.
- Same as above with wr_ready low on cycles 2-3 of WRITE -> wr_valid stays high, lfsr_data holds 0x40 until accepted, sequence unchanged.
- LANES=4, seed_in=0xFE, num_beats=3 -> lane seeds 0xFE,0xFF,0x00,0x01; corrupt lane 2 on read beat 2 -> fail_lane=4'b0100, fail=1, still set after done.
- num_beats=0 -> no LOAD_WR cycle; done pulses 2 cycles after start; fail=0; wr_valid never asserted.
- abort during READ beat 1 -> IDLE next cycle, no done, busy=0; a new start clears fail_lane and the test completes normally.
- Assert reset_n during WRITE -> all outputs at reset values immediately; start pulsed during busy -> ignored, no double test.

Source files
------------

// File: rtl/ddr2_ex_lfsr_sequencer_if.sv
// Bundle of the sequencer's control, write, read and LFSR-bank signals.
// The master modport is the sequencer itself; slave is the surrounding driver.
// Handshakes: a write beat transfers on a cycle where wr_valid and wr_ready are
// both high; a read beat transfers on any cycle where rd_valid is high while
// the sequencer is reading (there is no read back-pressure).
interface ddr2_ex_lfsr_sequencer_if #(
  parameter int LANES   = 4,
  parameter int BEATS_W = 8
);
  logic                 start;
  logic                 abort;
  logic [BEATS_W-1:0]   num_beats;
  logic [7:0]           seed_in;
  logic                 wr_ready;
  logic                 rd_valid;
  logic [8*LANES-1:0]   rd_data;
  logic [8*LANES-1:0]   lfsr_data;
  logic                 lfsr_enable;
  logic                 lfsr_pause;
  logic                 lfsr_load;
  logic [8*LANES-1:0]   lfsr_ldata;
  logic                 wr_valid;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [LANES-1:0]     fail_lane;
  logic [2:0]           dbg_state;

  modport master (
    input  start, abort, num_beats, seed_in, wr_ready, rd_valid, rd_data,
           lfsr_data,
    output lfsr_enable, lfsr_pause, lfsr_load, lfsr_ldata, wr_valid, busy,
           done, fail, fail_lane, dbg_state
  );

  modport slave (
    output start, abort, num_beats, seed_in, wr_ready, rd_valid, rd_data,
           lfsr_data,
    input  lfsr_enable, lfsr_pause, lfsr_load, lfsr_ldata, wr_valid, busy,
           done, fail, fail_lane, dbg_state
  );
endinterface

// File: rtl/ddr2_ex_lfsr_sequencer.sv
// Write-then-read LFSR test sequencer for the DDR2 example driver.
// Seeds a bank of 8-bit LFSRs, steps them per accepted write beat, re-seeds,
// then steps them per returned read beat and records per-lane mismatches.
module ddr2_ex_lfsr_sequencer #(
  parameter int LANES   = 4,
  parameter int BEATS_W = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  ddr2_ex_lfsr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_WR = 3'd1,
    WRITE   = 3'd2,
    LOAD_RD = 3'd3,
    READ    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BEATS_W-1:0]  cnt;
  logic [BEATS_W-1:0]  nb_q;
  logic [7:0]          seed_q;
  logic [LANES-1:0]    fail_lane_q;
  logic                done_q;
  logic                last_beat;
  logic [LANES-1:0]    mismatch;

  // Counter compare is exact; nb_q is never zero outside IDLE/DONE.
  assign last_beat = (cnt == (nb_q - BEATS_W'(1)));

  // Per-lane compare of returned read data against the regenerated pattern.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < LANES; i++) begin
      mismatch[i] = (bus.rd_data[8*i +: 8] != bus.lfsr_data[8*i +: 8]);
    end
  end

  // Lane seeds derive from the latched base seed, wrapping mod 256.
  always_comb begin
    bus.lfsr_ldata = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.lfsr_ldata[8*i +: 8] = seed_q + 8'(i);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.num_beats == '0) ? DONE : LOAD_WR;
        end
      end
      LOAD_WR: state_next = WRITE;
      WRITE: begin
        if (bus.wr_ready && last_beat) state_next = LOAD_RD;
      end
      LOAD_RD: state_next = READ;
      READ: begin
        if (bus.rd_valid && last_beat) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.abort) state_next = IDLE;
  end

  // State-decoded outputs; pause is the only input-dependent output.
  always_comb begin
    bus.lfsr_enable = 1'b0;
    bus.lfsr_load   = 1'b0;
    bus.lfsr_pause  = 1'b1;
    bus.wr_valid    = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      LOAD_WR, LOAD_RD: begin
        bus.lfsr_enable = 1'b1;
        bus.lfsr_load   = 1'b1;
      end
      WRITE: begin
        bus.lfsr_enable = 1'b1;
        bus.wr_valid    = 1'b1;
        bus.lfsr_pause  = !bus.wr_ready;
      end
      READ: begin
        bus.lfsr_enable = 1'b1;
        bus.lfsr_pause  = !bus.rd_valid;
      end
      default: begin
        bus.lfsr_enable = 1'b0;
      end
    endcase
  end

  // Datapath: latch test parameters, count beats, accumulate lane failures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      nb_q        <= '0;
      seed_q      <= '0;
      fail_lane_q <= '0;
    end else if (!bus.abort) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            nb_q        <= bus.num_beats;
            seed_q      <= bus.seed_in;
            fail_lane_q <= '0;
            cnt         <= '0;
          end
        end
        WRITE: begin
          if (bus.wr_ready) cnt <= last_beat ? '0 : cnt + BEATS_W'(1);
        end
        READ: begin
          if (bus.rd_valid) begin
            fail_lane_q <= fail_lane_q | mismatch;
            cnt         <= last_beat ? '0 : cnt + BEATS_W'(1);
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // Completion pulse is registered off the DONE state; an abort suppresses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= (state == DONE) && !bus.abort;
  end

  assign bus.done      = done_q;
  assign bus.fail_lane = fail_lane_q;
  assign bus.fail      = |fail_lane_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ddr2_ex_lfsr_sequencer.sv
// Directed bench for ddr2_ex_lfsr_sequencer with a behavioural LFSR bank
// (x^8+x^4+x^3+x^2+1, Galois form) and a write-data memory that feeds reads.
module tb_ddr2_ex_lfsr_sequencer;
  localparam int LANES   = 4;
  localparam int BEATS_W = 8;
  localparam logic [7:0] BUILTIN_SEED = 8'hA5;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] lfsr_q;

  ddr2_ex_lfsr_sequencer_if #(.LANES(LANES), .BEATS_W(BEATS_W)) bus ();

  ddr2_ex_lfsr_sequencer #(.LANES(LANES), .BEATS_W(BEATS_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  // Environment LFSR bank driven by the sequencer's controls.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= {LANES{BUILTIN_SEED}};
    end else if (!bus.lfsr_enable) begin
      lfsr_q <= {LANES{BUILTIN_SEED}};
    end else if (bus.lfsr_load) begin
      lfsr_q <= bus.lfsr_ldata;
    end else if (!bus.lfsr_pause) begin
      for (int i = 0; i < LANES; i++) lfsr_q[8*i +: 8] <= lfsr_step(lfsr_q[8*i +: 8]);
    end
  end
  assign bus.lfsr_data = lfsr_q;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: pulse start for one cycle; returns in the cycle after start.
  task automatic start_test(input logic [7:0] seed, input logic [7:0] nb);
    bus.start     = 1'b1;
    bus.seed_in   = seed;
    bus.num_beats = nb;
    tick();
    bus.start     = 1'b0;
  endtask

  // Driver + scoreboard for the write phase. stall bit c drops wr_ready on
  // WRITE cycle c. Returns in the cycle after the last accepted beat.
  task automatic write_phase(input int nb, input logic [15:0] stall);
    int acc;
    int cyc;
    logic [31:0] exp_v;
    acc = 0;
    cyc = 0;
    while (acc < nb && cyc < 64) begin
      bus.wr_ready = !stall[cyc[3:0]];
      #1;
      exp_v = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
      check_eq("wr_valid", {31'd0, bus.wr_valid}, 32'd1);
      check_eq("wr_data", bus.lfsr_data, exp_v);
      check_eq("wr_pause", {31'd0, bus.lfsr_pause}, {31'd0, !bus.wr_ready});
      if (bus.wr_ready) begin
        mem_q.push_back(bus.lfsr_data);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        acc++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    bus.wr_ready = 1'b0;
    if (acc < nb) check_eq("write_timeout", acc, nb);
  endtask

  // Driver for the read phase: returns memory contents, optionally corrupted
  // on one beat, optionally aborting on one beat.
  task automatic read_phase(input int nb, input int bad_beat, input logic [31:0] bad_mask,
                            input int abort_beat);
    for (int b = 0; b < nb; b++) begin
      bus.rd_valid = 1'b1;
      bus.rd_data  = ((b < mem_q.size()) ? mem_q[b] : 32'h0) ^ ((b == bad_beat) ? bad_mask : 32'h0);
      bus.abort    = (b == abort_beat);
      tick();
      if (b == abort_beat) break;
    end
    bus.rd_valid = 1'b0;
    bus.abort    = 1'b0;
  endtask

  // Called in the DONE-state cycle right after the last read beat.
  task automatic finish_checks(input string tag, input logic [3:0] exp_fl);
    check_eq({tag, "_fl_last"}, {28'd0, bus.fail_lane}, {28'd0, exp_fl});
    check_eq({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd1);
    check_eq({tag, "_enable_in_done"}, {31'd0, bus.lfsr_enable}, 32'd0);
    tick();
    check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check_eq({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_fail"}, {31'd0, bus.fail}, {31'd0, |exp_fl});
    tick();
    check_eq({tag, "_done_once"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_fl_hold"}, {28'd0, bus.fail_lane}, {28'd0, exp_fl});
  endtask

  task automatic push_seed20();
    exp_q.delete();
    mem_q.delete();
    exp_q.push_back(32'h2322_2120);
    exp_q.push_back(32'h4644_4240);
    exp_q.push_back(32'h8C88_8480);
    exp_q.push_back(32'h050D_151D);
  endtask

  task automatic push_seedfe();
    exp_q.delete();
    mem_q.delete();
    exp_q.push_back(32'h0100_FFFE);
    exp_q.push_back(32'h0200_E3E1);
    exp_q.push_back(32'h0400_DBDF);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_enable"}, {31'd0, bus.lfsr_enable}, 32'd0);
    check_eq({tag, "_load"}, {31'd0, bus.lfsr_load}, 32'd0);
    check_eq({tag, "_pause"}, {31'd0, bus.lfsr_pause}, 32'd1);
    check_eq({tag, "_wr_valid"}, {31'd0, bus.wr_valid}, 32'd0);
    check_eq({tag, "_fail_lane"}, {28'd0, bus.fail_lane}, 32'd0);
    check_eq({tag, "_ldata"}, bus.lfsr_ldata, 32'h0302_0100);
  endtask

  initial begin
    int d0;
    n_checks      = 0;
    n_errors      = 0;
    done_cnt      = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.num_beats = '0;
    bus.seed_in   = '0;
    bus.wr_ready  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;
    tick();

    // Seed 0x20, 4 beats, no stalls, clean readback.
    push_seed20();
    start_test(8'h20, 8'd4);
    check_eq("t1_load", {31'd0, bus.lfsr_load}, 32'd1);
    check_eq("t1_ldata", bus.lfsr_ldata, 32'h2322_2120);
    check_eq("t1_wr_valid_load", {31'd0, bus.wr_valid}, 32'd0);
    tick();
    write_phase(4, 16'h0000);
    check_eq("t1_load_rd", {31'd0, bus.lfsr_load}, 32'd1);
    tick();
    read_phase(4, -1, 32'h0, -1);
    finish_checks("t1", 4'b0000);

    // Same test with wr_ready low on WRITE cycles 2-3.
    push_seed20();
    start_test(8'h20, 8'd4);
    tick();
    write_phase(4, 16'h0006);
    tick();
    read_phase(4, -1, 32'h0, -1);
    finish_checks("t2", 4'b0000);

    // Seed 0xFE wraps across lanes; corrupt lane 2 on the second read beat.
    push_seedfe();
    start_test(8'hFE, 8'd3);
    check_eq("t3_ldata", bus.lfsr_ldata, 32'h0100_FFFE);
    tick();
    write_phase(3, 16'h0000);
    tick();
    read_phase(3, 1, 32'h0001_0000, -1);
    finish_checks("t3", 4'b0100);

    // Zero beats: straight to DONE, fail_lane cleared by start.
    start_test(8'h11, 8'd0);
    check_eq("t4_busy", {31'd0, bus.busy}, 32'd1);
    check_eq("t4_load", {31'd0, bus.lfsr_load}, 32'd0);
    check_eq("t4_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
    check_eq("t4_fl_clear", {28'd0, bus.fail_lane}, 32'd0);
    check_eq("t4_done_early", {31'd0, bus.done}, 32'd0);
    tick();
    check_eq("t4_done", {31'd0, bus.done}, 32'd1);
    check_eq("t4_fail", {31'd0, bus.fail}, 32'd0);
    tick();
    check_eq("t4_done_once", {31'd0, bus.done}, 32'd0);

    // Abort and start together in IDLE: start is dropped.
    bus.abort = 1'b1;
    start_test(8'h20, 8'd4);
    bus.abort = 1'b0;
    check_eq("t4b_abort_start", {31'd0, bus.busy}, 32'd0);
    tick();

    // Abort on read beat 1 after a lane-0 miscompare on beat 0.
    push_seed20();
    d0 = done_cnt;
    start_test(8'h20, 8'd4);
    tick();
    write_phase(4, 16'h0000);
    tick();
    read_phase(4, 0, 32'h0000_0001, 1);
    check_eq("t5_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("t5_fl_kept", {28'd0, bus.fail_lane}, 32'h1);
    repeat (3) tick();
    check_eq("t5_no_done", done_cnt, d0);
    push_seedfe();
    start_test(8'hFE, 8'd3);
    check_eq("t5_fl_cleared", {28'd0, bus.fail_lane}, 32'd0);
    tick();
    write_phase(3, 16'h0000);
    tick();
    read_phase(3, -1, 32'h0, -1);
    finish_checks("t5r", 4'b0000);

    // Reset mid-WRITE, then a start pulse while busy must be ignored.
    push_seed20();
    start_test(8'h20, 8'd4);
    tick();
    bus.wr_ready = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    bus.wr_ready = 1'b0;
    check_reset_values("t6_rst");
    #3;
    reset_n = 1'b1;
    tick();
    push_seed20();
    d0 = done_cnt;
    start_test(8'h20, 8'd4);
    bus.start = 1'b1;
    bus.seed_in = 8'h55;
    tick();
    bus.start = 1'b0;
    write_phase(4, 16'h0000);
    tick();
    read_phase(4, -1, 32'h0, -1);
    finish_checks("t6", 4'b0000);
    repeat (6) tick();
    check_eq("t6_single_done", done_cnt - d0, 32'd1);
    check_eq("t6_idle", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
